// File: rtl/int_divider_pkg.sv
// Shared types for the integer divider: op codes, FSM phases, result bundle
// and the small helpers that classify an op code.
package int_divider_pkg;

    localparam int DIVIDER_WIDTH      = 32;
    localparam int DIVIDER_ITERATIONS = DIVIDER_WIDTH;

    typedef enum logic [1:0] {
        DC_DIV  = 2'd0,
        DC_DIVU = 2'd1,
        DC_REM  = 2'd2,
        DC_REMU = 2'd3
    } int_div_code_e;

    typedef enum logic [1:0] {
        PHASE_IDLE = 2'd0,
        PHASE_CALC = 2'd1,
        PHASE_FIX  = 2'd2,
        PHASE_DONE = 2'd3
    } int_divider_phase_e;

    typedef struct packed {
        logic [DIVIDER_WIDTH-1:0] quotient;
        logic [DIVIDER_WIDTH-1:0] remainder;
    } divider_result_t;

    function automatic logic is_signed_op(input int_div_code_e op);
        return (op == DC_DIV) || (op == DC_REM);
    endfunction

    function automatic logic selects_quotient(input int_div_code_e op);
        return (op == DC_DIV) || (op == DC_DIVU);
    endfunction

endpackage

// File: rtl/int_divider_step.sv
// One radix-2 restoring step: shift {rem, quo} left and conditionally
// subtract the divisor, producing one quotient bit.
module int_divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] nextRem,
    output logic [WIDTH-1:0] nextQuo
);

    logic [WIDTH:0] shifted_rem;
    logic [WIDTH:0] trial;

    // The extra top bit keeps the shifted remainder exact for divisors >= 2^(WIDTH-1).
    assign shifted_rem = {rem, quo[WIDTH-1]};
    assign trial       = shifted_rem - {1'b0, divisor};

    assign nextRem = trial[WIDTH] ? shifted_rem[WIDTH-1:0] : trial[WIDTH-1:0];
    assign nextQuo = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/int_divider.sv
// Multi-cycle RISC-V M-extension divider (DIV/DIVU/REM/REMU), radix-2
// restoring, one quotient bit per cycle behind a start/busy/finished handshake.
module int_divider
    import int_divider_pkg::*;
#(
    parameter int DATA_WIDTH = DIVIDER_WIDTH,
    parameter int ITERATIONS = DIVIDER_ITERATIONS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  flush,
    input  logic [1:0]            code,
    input  logic [DATA_WIDTH-1:0] srcA,
    input  logic [DATA_WIDTH-1:0] srcB,
    output logic                  busy,
    output logic                  finished,
    output logic [DATA_WIDTH-1:0] dataOut
);

    localparam int CNT_W = $clog2(ITERATIONS + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ITERATIONS - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_VALUE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    int_divider_phase_e    state_reg, state_next;
    int_div_code_e         code_reg, code_next;
    logic [DATA_WIDTH-1:0] quo_reg, quo_next;
    logic [DATA_WIDTH-1:0] rem_reg, rem_next;
    logic [DATA_WIDTH-1:0] divisor_reg, divisor_next;
    logic [DATA_WIDTH-1:0] result_reg, result_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  q_sign_reg, q_sign_next;
    logic                  r_sign_reg, r_sign_next;

    // Operand conditioning on the request side
    int_div_code_e         code_in;
    logic                  in_signed;
    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] abs_a;
    logic [DATA_WIDTH-1:0] abs_b;
    logic                  div_zero;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] special_result;
    logic                  accepting;

    assign code_in   = int_div_code_e'(code);
    assign in_signed = is_signed_op(code_in);
    assign a_neg     = in_signed & srcA[DATA_WIDTH-1];
    assign b_neg     = in_signed & srcB[DATA_WIDTH-1];
    assign abs_a     = a_neg ? (~srcA + 1'b1) : srcA;
    assign abs_b     = b_neg ? (~srcB + 1'b1) : srcB;
    assign div_zero  = (srcB == '0);
    assign overflow  = in_signed && (srcA == MIN_VALUE) && (srcB == '1);
    assign accepting = start && ((state_reg == PHASE_IDLE) || (state_reg == PHASE_DONE));

    // Divide-by-zero takes precedence; it returns the raw dividend as remainder.
    always_comb begin
        special_result = '0;
        if (div_zero) begin
            special_result = selects_quotient(code_in) ? '1 : srcA;
        end else begin
            special_result = selects_quotient(code_in) ? MIN_VALUE : '0;
        end
    end

    logic [DATA_WIDTH-1:0] step_rem;
    logic [DATA_WIDTH-1:0] step_quo;

    int_divider_step #(
        .WIDTH (DATA_WIDTH)
    ) u_step (
        .rem     (rem_reg),
        .quo     (quo_reg),
        .divisor (divisor_reg),
        .nextRem (step_rem),
        .nextQuo (step_quo)
    );

    // Sign correction applied in FIX
    divider_result_t fixed;
    always_comb begin
        fixed.quotient  = (is_signed_op(code_reg) && q_sign_reg) ? (~quo_reg + 1'b1) : quo_reg;
        fixed.remainder = (is_signed_op(code_reg) && r_sign_reg) ? (~rem_reg + 1'b1) : rem_reg;
    end

    always_comb begin
        state_next   = state_reg;
        code_next    = code_reg;
        quo_next     = quo_reg;
        rem_next     = rem_reg;
        divisor_next = divisor_reg;
        result_next  = result_reg;
        count_next   = count_reg;
        q_sign_next  = q_sign_reg;
        r_sign_next  = r_sign_reg;

        if (flush) begin
            state_next = PHASE_IDLE;
        end else begin
            case (state_reg)
                PHASE_IDLE, PHASE_DONE: begin
                    if (accepting) begin
                        code_next    = code_in;
                        quo_next     = abs_a;
                        divisor_next = abs_b;
                        rem_next     = '0;
                        count_next   = '0;
                        q_sign_next  = a_neg ^ b_neg;
                        r_sign_next  = a_neg;
                        if (div_zero || overflow) begin
                            result_next = special_result;
                            state_next  = PHASE_DONE;
                        end else begin
                            state_next  = PHASE_CALC;
                        end
                    end
                end
                PHASE_CALC: begin
                    rem_next   = step_rem;
                    quo_next   = step_quo;
                    count_next = count_reg + CNT_W'(1);
                    if (count_reg == LAST_COUNT) begin
                        state_next = PHASE_FIX;
                    end
                end
                PHASE_FIX: begin
                    result_next = selects_quotient(code_reg) ? fixed.quotient : fixed.remainder;
                    state_next  = PHASE_DONE;
                end
                default: state_next = PHASE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= PHASE_IDLE;
            code_reg    <= DC_DIV;
            quo_reg     <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            result_reg  <= '0;
            count_reg   <= '0;
            q_sign_reg  <= 1'b0;
            r_sign_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            code_reg    <= code_next;
            quo_reg     <= quo_next;
            rem_reg     <= rem_next;
            divisor_reg <= divisor_next;
            result_reg  <= result_next;
            count_reg   <= count_next;
            q_sign_reg  <= q_sign_next;
            r_sign_reg  <= r_sign_next;
        end
    end

    assign busy     = (state_reg == PHASE_CALC) || (state_reg == PHASE_FIX);
    assign finished = (state_reg == PHASE_DONE);
    assign dataOut  = result_reg;

endmodule

// File: tb/tb_int_divider.sv
// Scoreboard bench for int_divider: expected result, latency and busy count
// are queued at start and compared when finished rises.
module tb_int_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [1:0]  code;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        finished;
    logic [31:0] dataOut;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          busy_q[$];
    logic [31:0] last_result;

    localparam logic [1:0] C_DIV = 2'd0, C_DIVU = 2'd1, C_REM = 2'd2, C_REMU = 2'd3;

    int_divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .flush    (flush),
        .code     (code),
        .srcA     (srcA),
        .srcB     (srcB),
        .busy     (busy),
        .finished (finished),
        .dataOut  (dataOut)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               want_q;
        logic               sgn;
        sa     = a;
        sb     = b;
        want_q = (c == C_DIV) || (c == C_DIVU);
        sgn    = (c == C_DIV) || (c == C_REM);
        if (b == 32'd0) return want_q ? 32'hFFFF_FFFF : a;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_q ? 32'h8000_0000 : 32'd0;
        case (c)
            C_DIV:   return sa / sb;
            C_DIVU:  return a / b;
            C_REM:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic logic is_special(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        sgn = (c == C_DIV) || (c == C_REM);
        return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Drives one request, optionally pulses a junk start while busy, and
    // scores the result when finished rises. Returns at #1 after that edge.
    task automatic run_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                          input int noise_cycle);
        int          cyc;
        int          busy_cnt;
        logic [31:0] exp_v;
        int          exp_lat;
        int          exp_busy;
        exp_q.push_back(model(c, a, b));
        lat_q.push_back(is_special(c, a, b) ? 1 : 34);
        busy_q.push_back(is_special(c, a, b) ? 0 : 33);
        code  = c;
        srcA  = a;
        srcB  = b;
        start = 1'b1;
        cyc      = 0;
        busy_cnt = 0;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            if (busy) busy_cnt++;
            if (cyc == noise_cycle) begin
                start = 1'b1;
                code  = 2'($urandom_range(3));
                srcA  = $urandom;
                srcB  = $urandom;
            end
        end while (!finished && cyc < 60);
        start    = 1'b0;
        exp_v    = exp_q.pop_front();
        exp_lat  = lat_q.pop_front();
        exp_busy = busy_q.pop_front();
        check_value("finished_seen", 32'(finished), 32'd1);
        check_value("result", dataOut, exp_v);
        check_value("latency", 32'(cyc), 32'(exp_lat));
        check_value("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        last_result = exp_v;
        $display("op code=%0d a=%h b=%h result=%h expected=%h latency=%0d", c, a, b, dataOut, exp_v, cyc);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        code  = 2'd0;
        srcA  = '0;
        srcB  = '0;
        last_result = '0;
        repeat (2) @(posedge clk);
        #1;
        check_value("reset_busy", 32'(busy), 32'd0);
        check_value("reset_finished", 32'(finished), 32'd0);
        check_value("reset_data", dataOut, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unsigned, signed, divide-by-zero and overflow, all back-to-back
        run_op(C_DIVU, 32'd100, 32'd7, 0);
        run_op(C_REMU, 32'd100, 32'd7, 0);
        run_op(C_DIV,  32'hFFFF_FFF9, 32'd2, 0);
        run_op(C_REM,  32'hFFFF_FFF9, 32'd2, 0);
        run_op(C_REM,  32'd7, 32'hFFFF_FFFE, 0);
        run_op(C_DIVU, 32'h1234, 32'd0, 0);
        run_op(C_REM,  32'h1234, 32'd0, 0);
        run_op(C_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(C_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(C_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 0);

        // DONE holds the result while idle
        repeat (3) @(posedge clk);
        #1;
        check_value("hold_finished", 32'(finished), 32'd1);
        check_value("hold_data", dataOut, last_result);

        // Flush at cycle 10 of a DIVU
        code  = C_DIVU;
        srcA  = 32'd5000;
        srcB  = 32'd3;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        check_value("flush_busy", 32'(busy), 32'd0);
        check_value("flush_finished", 32'(finished), 32'd0);
        check_value("flush_data_kept", dataOut, last_result);
        // Flush and start on the same edge: request dropped
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check_value("flush_wins_busy", 32'(busy), 32'd0);
        check_value("flush_wins_finished", 32'(finished), 32'd0);
        @(posedge clk);
        #1;
        check_value("flush_idle_busy", 32'(busy), 32'd0);
        run_op(C_DIVU, 32'hFFFF_FFFF, 32'h10, 0);

        // Asynchronous reset mid-CALC
        code  = C_DIV;
        srcA  = 32'd99999;
        srcB  = 32'd13;
        start = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check_value("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("async_reset_busy", 32'(busy), 32'd0);
        check_value("async_reset_finished", 32'(finished), 32'd0);
        check_value("async_reset_data", dataOut, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back with ignored start pulses during busy
        run_op(C_DIV,  32'd1000, 32'hFFFF_FFFD, 5);
        run_op(C_REMU, 32'hDEAD_BEEF, 32'd12345, 20);

        // Random mix
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  rc;
            logic [31:0] ra;
            logic [31:0] rb;
            rc = 2'($urandom_range(3));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            run_op(rc, ra, rb, (i % 3 == 0) ? 12 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
